// File: rtl/alu_pkg.sv
// Shared opcode and width constants for the registered ALU slice.
// Imported by the top-level datapath and the multiplier sub-module.
package alu_pkg;

  localparam int W4    = 4;
  localparam int W6    = 6;
  localparam int W8    = 8;
  localparam int RES_W = 12;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

endpackage

// File: rtl/alu_mul6.sv
// Combinational 6x6 unsigned multiplier with a full-width 12-bit product.
module alu_mul6
  import alu_pkg::*;
(
  input  logic [W6-1:0]    a,
  input  logic [W6-1:0]    b,
  output logic [RES_W-1:0] p
);

  // Extend both operands before multiplying so the product is never truncated.
  assign p = {{(RES_W-W6){1'b0}}, a} * {{(RES_W-W6){1'b0}}, b};

endmodule

// File: rtl/alu.sv
// Registered four-operation ALU: one combinational select on alu_sel feeding
// a single output register with asynchronous active-low clear.
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W4-1:0]    A_4,
  input  logic [W4-1:0]    B_4,
  input  logic [W6-1:0]    A_6,
  input  logic [W6-1:0]    B_6,
  input  logic [W8-1:0]    A_8,
  input  logic [W8-1:0]    B_8,
  input  logic [1:0]       alu_sel,
  input  logic             carry_in,
  output logic [RES_W-1:0] result,
  output logic             carry_out
);

  logic [RES_W-1:0] mul_p;
  logic [W4:0]      sum5;
  logic [W8:0]      diff9;
  logic [RES_W-1:0] result_nxt;
  logic             carry_nxt;

  alu_mul6 u_mul6 (
    .a (A_6),
    .b (B_6),
    .p (mul_p)
  );

  assign sum5  = {1'b0, A_4} + {1'b0, B_4} + {{W4{1'b0}}, carry_in};
  // Bit 8 of the 9-bit difference is the borrow: set exactly when A_8 < B_8 + carry_in.
  assign diff9 = {1'b0, A_8} - {1'b0, B_8} - {{W8{1'b0}}, carry_in};

  always_comb begin
    result_nxt = '0;
    carry_nxt  = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        result_nxt = {{(RES_W-W4){1'b0}}, sum5[W4-1:0]};
        carry_nxt  = sum5[W4];
      end
      OP_SUB: begin
        result_nxt = {{(RES_W-W8){1'b0}}, diff9[W8-1:0]};
        carry_nxt  = diff9[W8];
      end
      OP_MUL: begin
        result_nxt = mul_p;
      end
      OP_AND: begin
        result_nxt = {{(RES_W-W4){1'b0}}, A_4 & B_4};
      end
      default: begin
        result_nxt = '0;
        carry_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      result    <= result_nxt;
      carry_out <= carry_nxt;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU: hand-computed expectations,
// latency/hold checks, unused-operand isolation and asynchronous reset.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [3:0]  A_4, B_4;
  logic [5:0]  A_6, B_6;
  logic [7:0]  A_8, B_8;
  logic [1:0]  alu_sel;
  logic        carry_in;
  logic [11:0] result;
  logic        carry_out;

  int n_checks;
  int n_fail;

  logic [11:0] prev_res;
  logic        prev_co;

  alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A_4       (A_4),
    .B_4       (B_4),
    .A_6       (A_6),
    .B_6       (B_6),
    .A_8       (A_8),
    .B_8       (B_8),
    .alu_sel   (alu_sel),
    .carry_in  (carry_in),
    .result    (result),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a vector at the falling edge, confirm the outputs still hold the
  // previous result, then check the new result one rising edge later.
  task automatic run_op(input string tag, input logic [1:0] sel,
                        input logic [3:0] a4, input logic [3:0] b4,
                        input logic [5:0] a6, input logic [5:0] b6,
                        input logic [7:0] a8, input logic [7:0] b8,
                        input logic cin,
                        input logic [11:0] exp_res, input logic exp_co);
    @(negedge clk);
    alu_sel  = sel;
    A_4 = a4; B_4 = b4; A_6 = a6; B_6 = b6; A_8 = a8; B_8 = b8;
    carry_in = cin;
    #1;
    chk({tag, "_hold_res"}, 16'(result), 16'(prev_res));
    chk({tag, "_hold_co"},  16'(carry_out), 16'(prev_co));
    @(posedge clk);
    #1;
    chk({tag, "_res"}, 16'(result), 16'(exp_res));
    chk({tag, "_co"},  16'(carry_out), 16'(exp_co));
    prev_res = exp_res;
    prev_co  = exp_co;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    alu_sel  = 2'b00;
    A_4 = 4'd0; B_4 = 4'd0; A_6 = 6'd0; B_6 = 6'd0; A_8 = 8'd0; B_8 = 8'd0;
    carry_in = 1'b0;
    prev_res = 12'h000;
    prev_co  = 1'b0;

    #2;
    chk("reset_res", 16'(result), 16'h0000);
    chk("reset_co",  16'(carry_out), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    //      tag        sel    a4     b4     a6     b6     a8      b8      cin  res     co
    run_op("add_5_3",  2'b00, 4'd5,  4'd3,  6'd9,  6'd9,  8'd200, 8'd1,   1'b0, 12'h008, 1'b0);
    run_op("add_15_1", 2'b00, 4'd15, 4'd1,  6'd63, 6'd63, 8'd0,   8'd255, 1'b0, 12'h000, 1'b1);
    run_op("add_wrap", 2'b00, 4'd15, 4'd15, 6'd1,  6'd2,  8'd7,   8'd9,   1'b1, 12'h00F, 1'b1);
    run_op("add_6_8c", 2'b00, 4'd6,  4'd8,  6'd0,  6'd0,  8'd0,   8'd0,   1'b1, 12'h00F, 1'b0);
    run_op("sub_100",  2'b01, 4'd15, 4'd15, 6'd63, 6'd63, 8'd100, 8'd25,  1'b0, 12'h04B, 1'b0);
    run_op("sub_25",   2'b01, 4'd0,  4'd0,  6'd0,  6'd0,  8'd25,  8'd100, 1'b0, 12'h0B5, 1'b1);
    run_op("sub_wrap", 2'b01, 4'd3,  4'd4,  6'd5,  6'd6,  8'd0,   8'd255, 1'b1, 12'h000, 1'b1);
    run_op("sub_eq",   2'b01, 4'd0,  4'd0,  6'd0,  6'd0,  8'd50,  8'd49,  1'b1, 12'h000, 1'b0);
    run_op("mul_15_3", 2'b10, 4'd15, 4'd15, 6'd15, 6'd3,  8'd255, 8'd0,   1'b1, 12'h02D, 1'b0);
    run_op("mul_max",  2'b10, 4'd0,  4'd0,  6'd63, 6'd63, 8'd0,   8'd0,   1'b0, 12'hF81, 1'b0);
    run_op("and_d_a",  2'b11, 4'hD,  4'hA,  6'd0,  6'd0,  8'd0,   8'd0,   1'b1, 12'h008, 1'b0);
    run_op("and_iso",  2'b11, 4'hD,  4'hA,  6'd63, 6'd63, 8'd255, 8'd255, 1'b0, 12'h008, 1'b0);
    run_op("sel_x",    2'bxx, 4'd0,  4'd0,  6'd0,  6'd0,  8'd0,   8'd0,   1'b0, 12'h000, 1'b0);

    // Mid-stream reset with a nonzero result and carry held in the register.
    run_op("pre_rst",  2'b01, 4'd0,  4'd0,  6'd0,  6'd0,  8'd25,  8'd100, 1'b0, 12'h0B5, 1'b1);
    @(negedge clk);
    alu_sel = 2'b10; A_6 = 6'd63; B_6 = 6'd63;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_res", 16'(result), 16'h0000);
    chk("midrst_co",  16'(carry_out), 16'h0000);
    @(posedge clk);
    #1;
    chk("rst_held_res", 16'(result), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    alu_sel = 2'b00; A_4 = 4'd15; B_4 = 4'd15; carry_in = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_res", 16'(result), 16'h000F);
    chk("post_rst_co",  16'(carry_out), 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
